sum_narrow_accumulator: RTL

//   Consumer end of the ADDER sum path: receives signed N+1-bit sign-extended adder

---
 rtl/sum_narrow_accumulator.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sum_narrow_accumulator.sv
// sum_narrow_accumulator
//   Accumulates framed, sign-extended N+1-bit adder sums into an ACC_W-bit
//   register and emits one scaled, narrowed N-bit result per frame, plus an
//   overflow flag.
//   Build option: define SUM_NARROW_SAT_EN to saturate out-of-range results;
//   otherwise out-of-range results wrap to the low N bits.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   ACC   | accepting beats of a frame (s_ready=1)
//   OUT   | frame result presented on m_data/m_ovf until m_ready (s_ready=0)

module sum_narrow_accumulator #(
    parameter int N     = 16,
    parameter int ACC_W = 24,
    parameter int SHIFT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N:0]   s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data,
    output logic         m_ovf,
    output logic         busy
);

    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    logic [0:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    fovf_q, fovf_d;
    logic                    active_q, active_d;
    logic [N-1:0]            m_data_q, m_data_d;
    logic                    m_ovf_q, m_ovf_d;

    logic signed [ACC_W-1:0] s_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] t;
    logic [ACC_W-N:0]        t_upper;
    logic                    add_ovf;
    logic                    in_range;
    logic                    accept;
    logic [N-1:0]            narrowed;

    assign s_ready = (state_q == ST_ACC) && rst_n;
    assign m_valid = (state_q == ST_OUT);
    assign m_data  = m_data_q;
    assign m_ovf   = m_ovf_q;
    assign busy    = (state_q == ST_OUT) || active_q;
    assign accept  = s_valid && s_ready;

    // Datapath: running sum, signed-overflow detect, scaling and narrowing.
    always_comb begin
        s_ext    = ACC_W'($signed(s_data));
        sum      = acc_q + s_ext;
        add_ovf  = (acc_q[ACC_W-1] == s_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        t        = sum >>> SHIFT;
        // In range only when all bits from N-1 upward match the sign.
        t_upper  = t[ACC_W-1:N-1];
        in_range = (&t_upper) || !(|t_upper);
`ifdef SUM_NARROW_SAT_EN
        if (in_range) begin
            narrowed = t[N-1:0];
        end else if (t[ACC_W-1]) begin
            narrowed = {1'b1, {(N-1){1'b0}}};
        end else begin
            narrowed = {1'b0, {(N-1){1'b1}}};
        end
`else
        narrowed = t[N-1:0];
`endif
    end

    // Next-state logic for the FSM, accumulator and result registers.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        fovf_d   = fovf_q;
        active_d = active_q;
        m_data_d = m_data_q;
        m_ovf_d  = m_ovf_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (s_last) begin
                        m_data_d = narrowed;
                        m_ovf_d  = !in_range || fovf_q || add_ovf;
                        acc_d    = '0;
                        fovf_d   = 1'b0;
                        active_d = 1'b0;
                        state_d  = ST_OUT;
                    end else begin
                        acc_d    = sum;
                        fovf_d   = fovf_q || add_ovf;
                        active_d = 1'b1;
                    end
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // Registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_ACC;
            acc_q    <= '0;
            fovf_q   <= 1'b0;
            active_q <= 1'b0;
            m_data_q <= '0;
            m_ovf_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            fovf_q   <= fovf_d;
            active_q <= active_d;
            m_data_q <= m_data_d;
            m_ovf_q  <= m_ovf_d;
        end
    end

endmodule
